seg7_scan_controller: RTL and testbench

- Sequencer that shares one 4-bit BCD-to-7-segment decoder across four multiplexed display digits.
- Accepts a 10-bit unsigned processor value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the stored digits onto the shared decoder input and drives active-low digit enables.
- Sits between the processor output register and the board display.

---
 rtl/seg7_scan_controller.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Converts a binary value to four BCD digits with a sequential shift-add-3
// (double-dabble) engine. The stored digits are time-multiplexed onto one
// shared BCD-to-7-segment decoder, with active-low digit enables.
//
// Handshake: load is a strobe that is sampled only while busy=0. On the
// accepting edge busy rises. It stays high for DATA_WIDTH edges and falls on
// the edge that publishes the result. load pulses seen while busy=1 are
// dropped. There is no queueing and no restart. The display register keeps
// the previous result until that final edge, so no partial digits are shown.

module seg7_scan_controller #(
    parameter int DATA_WIDTH    = 10,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic [3:0]            digit_bcd,
    output logic [3:0]            digit_sel,
    output logic                  o_dbg_state
);

    // Four BCD digits sit above the binary field in one shift register
    localparam int BCD_W = 16;
    localparam int SR_W  = BCD_W + DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Conversion engine state
    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_iter;
    logic [SR_W-1:0]    r_shift;
    logic [BCD_W-1:0]   r_disp;

    // Scanner state
    logic [PRE_W-1:0]   r_pre;
    logic [1:0]         r_idx;
    logic [3:0]         r_sel;
    logic [3:0]         r_bcd;

    // Combinational helpers
    logic [SR_W-1:0]    w_step;
    logic               w_last;
    logic [BCD_W-1:0]   w_disp_next;
    logic               w_pre_tc;
    logic [1:0]         w_idx_next;
    logic [3:0]         w_nib;
    logic [3:0]         w_zero_above;
    logic [3:0]         w_bcd_next;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    // Each nibble is <= 9 before the add, so the 4-bit sum cannot overflow.
    always_comb begin
        w_step = r_shift;
        for (int k = 0; k < 4; k++) begin
            if (r_shift[DATA_WIDTH + 4*k +: 4] >= 4'd5) begin
                w_step[DATA_WIDTH + 4*k +: 4] = r_shift[DATA_WIDTH + 4*k +: 4] + 4'd3;
            end
        end
        w_step = w_step << 1;
    end

    // Final step detection and the display value that will hold after this edge
    always_comb begin
        w_last      = (r_state == S_CONV) && (r_iter == LAST_STEP);
        w_disp_next = w_last ? w_step[SR_W-1 -: BCD_W] : r_disp;
    end

    // Conversion FSM: capture on load in IDLE, step once per cycle in CONV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_iter  <= '0;
            r_shift <= '0;
            r_disp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= {{BCD_W{1'b0}}, value};
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_step;
                    if (w_last) begin
                        r_disp  <= w_step[SR_W-1 -: BCD_W];
                        r_iter  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan timing: prescaler terminal count advances the digit index
    always_comb begin
        w_pre_tc   = (r_pre == PRE_LAST);
        w_idx_next = w_pre_tc ? r_idx + 2'd1 : r_idx;
    end

    // Leading-zero detection on the display value seen after this edge.
    // w_zero_above[k] is set when nibble k and every higher nibble are zero.
    // The units digit (k=0) is never blanked.
    always_comb begin
        w_zero_above[3] = (w_disp_next[15:12] == 4'd0);
        w_zero_above[2] = w_zero_above[3] && (w_disp_next[11:8] == 4'd0);
        w_zero_above[1] = w_zero_above[2] && (w_disp_next[7:4] == 4'd0);
        w_zero_above[0] = 1'b0;
        w_nib           = w_disp_next[4*w_idx_next +: 4];
        if ((BLANK_LEADING != 0) && w_zero_above[w_idx_next]) begin
            w_bcd_next = 4'hF;
        end else begin
            w_bcd_next = w_nib;
        end
    end

    // Free-running scanner. Select and nibble are registered together from the
    // same next index and next display value, so they switch on one edge and a
    // display update on a scan edge applies to the newly selected digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
            r_sel <= 4'b1110;
            r_bcd <= 4'h0;
        end else begin
            r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
            r_idx <= w_idx_next;
            r_sel <= ~(4'b0001 << w_idx_next);
            r_bcd <= w_bcd_next;
        end
    end

    assign busy        = r_busy;
    assign digit_bcd   = r_bcd;
    assign digit_sel   = r_sel;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller (REFRESH_DIV=4, leading-zero blanking on).
// A decimal-arithmetic reference model tracks busy, the displayed value and
// the scan position. Every negedge compares the DUT against that model.
// A vector table and hand-written sequences add direct checks.

module tb_seg7_scan_controller;

    localparam int DW = 10;
    localparam int RD = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] value = '0;
    logic          busy;
    logic [3:0]    digit_bcd;
    logic [3:0]    digit_sel;
    logic          dbg_state;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .DATA_WIDTH   (DW),
        .REFRESH_DIV  (RD),
        .BLANK_LEADING(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .busy       (busy),
        .digit_bcd  (digit_bcd),
        .digit_sel  (digit_sel),
        .o_dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // ---------------- reference model ----------------
    int m_disp  = 0;   // value currently shown (decimal integer)
    int m_pend  = 0;   // value being converted
    int m_left  = 0;   // edges remaining until result is published
    int m_edges = 0;   // edges since reset, modulo one full scan
    bit m_busy  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_disp  <= 0;
            m_left  <= 0;
            m_edges <= 0;
        end else begin
            m_edges <= (m_edges + 1) % (4 * RD);
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_disp <= m_pend;
                end
                m_left <= m_left - 1;
            end else if (load) begin
                m_busy <= 1'b1;
                m_pend <= int'(value);
                m_left <= 10;
            end
        end
    end

    // Digit k of a decimal number with leading-zero blanking (k>=1 only)
    function automatic logic [3:0] exp_digit(int d, int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k >= 1 && d < p) return 4'hF;
        return 4'((d / p) % 10);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int idx;
        idx = m_edges / RD;
        check("busy", int'(busy), int'(m_busy));
        check("dbg_state", int'(dbg_state), int'(m_busy));
        check("digit_sel", int'(digit_sel), int'(sel_tab[idx]));
        check("digit_bcd", int'(digit_bcd), int'(exp_digit(m_disp, idx)));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    // Strobe load for one edge, then count edges with busy high (expect 10)
    task automatic load_and_wait(int v);
        int n;
        load  = 1'b1;
        value = DW'(v);
        tick();
        load  = 1'b0;
        n = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        check("busy_len", n, 10);
    endtask

    // Walk one full scan, checking each digit's nibble and its hold time
    task automatic scan_check(logic [15:0] exp);
        int w;
        int n;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (digit_sel !== sel_tab[k] && w < 4 * RD + 2) begin
                tick();
                w++;
            end
            check("scan_reach", int'(digit_sel), int'(sel_tab[k]));
            check("scan_nibble", int'(digit_bcd), int'(exp[4*k +: 4]));
            if (k >= 1) begin
                n = 1;
                for (int i = 0; i < RD + 2; i++) begin
                    tick();
                    if (digit_sel !== sel_tab[k]) break;
                    n++;
                end
                check("scan_hold", n, RD);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          v;
        logic [15:0] exp;
    } vec_t;

    vec_t tab [8];

    initial begin
        int n;

        tab[0] = '{1023, 16'h1023};
        tab[1] = '{7,    16'hFFF7};
        tab[2] = '{0,    16'hFFF0};
        tab[3] = '{100,  16'hF100};
        tab[4] = '{999,  16'hF999};
        tab[5] = '{10,   16'hFF10};
        tab[6] = '{1000, 16'h1000};
        tab[7] = '{58,   16'hFF58};

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(digit_sel), int'(4'b1110));
        check("rst_bcd", int'(digit_bcd), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven conversions
        for (int t = 0; t < 8; t++) begin
            load_and_wait(tab[t].v);
            scan_check(tab[t].exp);
        end

        // load while busy is ignored
        load  = 1'b1;
        value = DW'(512);
        tick();
        load = 1'b0;
        n = 1;
        tick(); n++;
        tick(); n++;
        load  = 1'b1;
        value = DW'(999);
        tick();
        if (busy) n++;
        load = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        check("ignored_busy_len", n, 10);
        scan_check(16'hF512);

        // Reset in the middle of a conversion
        load_and_wait(321);
        scan_check(16'hF321);
        load  = 1'b1;
        value = DW'(845);
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sel", int'(digit_sel), int'(4'b1110));
        check("async_rst_bcd", int'(digit_bcd), 0);
        tick();
        tick();
        rst_n = 1'b1;
        load_and_wait(845);
        scan_check(16'hF845);

        // Back-to-back: new strobe raised as soon as busy is seen low
        load_and_wait(250);
        check("b2b_busy_low", int'(busy), 0);
        load_and_wait(9);
        scan_check(16'hFFF9);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 3) == 0);
            value = DW'($urandom_range(0, 1023));
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
